// File: rtl/axi_llc_write_unit_pkg.sv
// rtl/axi_llc_write_unit_pkg.sv - LLC write unit geometry, channel types and AXI address helpers
package axi_llc_write_unit_pkg;

  // 512-bit data path, 8 words per line, 32 sets, 8 ways
  localparam int unsigned ADDR_WIDTH          = 32;
  localparam int unsigned ID_WIDTH            = 4;
  localparam int unsigned DATA_WIDTH          = 512;
  localparam int unsigned STRB_WIDTH          = DATA_WIDTH / 8;
  localparam int unsigned BYTE_OFFSET_LENGTH  = 6;
  localparam int unsigned BLOCK_OFFSET_LENGTH = 3;
  localparam int unsigned INDEX_LENGTH        = 5;
  localparam int unsigned INDEX_BASE          = BYTE_OFFSET_LENGTH + BLOCK_OFFSET_LENGTH;
  localparam int unsigned SET_ASSOCIATIVITY   = 8;

  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_e;
  typedef enum logic [1:0] {R_CHAN_UNIT, W_CHAN_UNIT} cache_unit_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]          a_x_id;
    logic [ADDR_WIDTH-1:0]        a_x_addr;
    logic [7:0]                   a_x_len;
    logic [2:0]                   a_x_size;
    burst_e                       a_x_burst;
    resp_e                        x_resp;
    logic                         x_last;
    logic [SET_ASSOCIATIVITY-1:0] way_ind;
    logic [INDEX_LENGTH-1:0]      index_partition;
  } desc_t;

  typedef struct packed {
    cache_unit_e                   cache_unit;
    logic [SET_ASSOCIATIVITY-1:0]  way_ind;
    logic [INDEX_LENGTH-1:0]       line_addr;
    logic [BLOCK_OFFSET_LENGTH-1:0] blk_offset;
    logic                          we;
    logic [DATA_WIDTH-1:0]         data;
    logic [STRB_WIDTH-1:0]         strb;
  } way_inp_t;

  typedef struct packed {
    logic [INDEX_LENGTH-1:0]      index;
    logic [SET_ASSOCIATIVITY-1:0] way_ind;
  } lock_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    resp_e               resp;
  } b_chan_t;

  function automatic logic [ADDR_WIDTH-1:0] num_bytes(input logic [2:0] size);
    return ADDR_WIDTH'(1) << size;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] aligned_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size);
    return addr & ~(num_bytes(size) - ADDR_WIDTH'(1));
  endfunction

endpackage

// File: rtl/axi_llc_write_unit_if.sv
// rtl/axi_llc_write_unit_if.sv - descriptor, W/B, data-way and line-unlock channels of the write unit
interface axi_llc_write_unit_if;
  import axi_llc_write_unit_pkg::*;

  desc_t    desc_i;
  logic     desc_valid_i;
  logic     desc_ready_o;
  w_chan_t  w_chan_slv_i;
  logic     w_chan_valid_i;
  logic     w_chan_ready_o;
  b_chan_t  b_chan_slv_o;
  logic     b_chan_valid_o;
  logic     b_chan_ready_i;
  way_inp_t way_inp_o;
  logic     way_inp_valid_o;
  logic     way_inp_ready_i;
  lock_t    w_unlock_o;
  logic     w_unlock_req_o;
  logic     w_unlock_gnt_i;

  // the write unit itself
  modport slave (
    input  desc_i, desc_valid_i, w_chan_slv_i, w_chan_valid_i, b_chan_ready_i,
           way_inp_ready_i, w_unlock_gnt_i,
    output desc_ready_o, w_chan_ready_o, b_chan_slv_o, b_chan_valid_o,
           way_inp_o, way_inp_valid_o, w_unlock_o, w_unlock_req_o
  );

  // the surrounding pipeline, slave port, data ways and bloom filter
  modport master (
    output desc_i, desc_valid_i, w_chan_slv_i, w_chan_valid_i, b_chan_ready_i,
           way_inp_ready_i, w_unlock_gnt_i,
    input  desc_ready_o, w_chan_ready_o, b_chan_slv_o, b_chan_valid_o,
           way_inp_o, way_inp_valid_o, w_unlock_o, w_unlock_req_o
  );
endinterface

// File: rtl/axi_llc_write_unit.sv
// rtl/axi_llc_write_unit.sv - LLC write unit: W beats to data ways, line unlock, B response
module axi_llc_write_unit
  import axi_llc_write_unit_pkg::*;
#(
  parameter bit CACHE_PARTITION = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_llc_write_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, UNLOCK, BRESP} state_e;

  state_e                  state_q, state_d;
  desc_t                   desc_q, desc_d;
  logic                    resp_ok;
  logic                    beat_done;
  logic [INDEX_LENGTH-1:0] line_index;

  // Error descriptors still consume their beats but never touch the data ways.
  assign resp_ok    = (desc_q.x_resp == RESP_OKAY);
  assign line_index = CACHE_PARTITION ? desc_q.index_partition
                                      : desc_q.a_x_addr[INDEX_BASE +: INDEX_LENGTH];
  assign beat_done  = bus.w_chan_valid_i & bus.w_chan_ready_o;

  // Handshake strobes decoded from the registered state.
  always_comb begin
    bus.desc_ready_o    = (state_q == IDLE);
    bus.w_chan_ready_o  = 1'b0;
    bus.way_inp_valid_o = 1'b0;
    if (state_q == WRITE) begin
      bus.w_chan_ready_o  = resp_ok ? bus.way_inp_ready_i : 1'b1;
      bus.way_inp_valid_o = bus.w_chan_valid_i & resp_ok;
    end
    bus.w_unlock_req_o  = (state_q == UNLOCK);
    bus.b_chan_valid_o  = (state_q == BRESP);
  end

  // Payloads come from the descriptor register, so they hold until their handshake.
  always_comb begin
    bus.way_inp_o            = '0;
    bus.way_inp_o.cache_unit = W_CHAN_UNIT;
    bus.way_inp_o.we         = 1'b1;
    bus.way_inp_o.way_ind    = desc_q.way_ind;
    bus.way_inp_o.line_addr  = line_index;
    bus.way_inp_o.blk_offset = desc_q.a_x_addr[BYTE_OFFSET_LENGTH +: BLOCK_OFFSET_LENGTH];
    bus.way_inp_o.data       = bus.w_chan_slv_i.data;
    bus.way_inp_o.strb       = bus.w_chan_slv_i.strb;
    bus.w_unlock_o.index     = line_index;
    bus.w_unlock_o.way_ind   = desc_q.way_ind;
    bus.b_chan_slv_o.id      = desc_q.a_x_id;
    bus.b_chan_slv_o.resp    = desc_q.x_resp;
  end

  // Next state and per-beat descriptor update; the beat count ends the burst, not W.last.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    case (state_q)
      IDLE: begin
        if (bus.desc_valid_i) begin
          desc_d  = bus.desc_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (beat_done) begin
          if (desc_q.a_x_len != 8'd0) begin
            desc_d.a_x_len = desc_q.a_x_len - 8'd1;
            if (desc_q.a_x_burst != BURST_FIXED) begin
              desc_d.a_x_addr = aligned_addr(desc_q.a_x_addr + num_bytes(desc_q.a_x_size),
                                             desc_q.a_x_size);
            end
          end else begin
            state_d = UNLOCK;
          end
        end
      end
      UNLOCK: begin
        if (bus.w_unlock_gnt_i) begin
          state_d = desc_q.x_last ? BRESP : IDLE;
        end
      end
      BRESP: begin
        if (bus.b_chan_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and descriptor registers; reset drops any burst in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
    end
  end

endmodule

// File: tb/tb_axi_llc_write_unit.sv
// tb/tb_axi_llc_write_unit.sv - self-checking bench for the LLC write unit
module tb_axi_llc_write_unit;
  import axi_llc_write_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_llc_write_unit_if bus ();

  axi_llc_write_unit #(.CACHE_PARTITION(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_WIDTH-1:0] beat_data [256];
  logic [STRB_WIDTH-1:0] beat_strb [256];
  way_inp_t got_wr[$];
  way_inp_t exp_wr[$];
  int n_drained, n_unlock, n_b, first_wr_cyc, last_wr_cyc, unlock_cyc, b_cyc;
  int way_valid_seen, unlock_unstable, b_unstable, ready_early, wready_mismatch;
  int unlock_req_cycles, b_valid_cycles;
  bit idle_after, timed_out;
  lock_t   got_unlock;
  b_chan_t got_b;

  function automatic logic [DATA_WIDTH-1:0] rand_data();
    logic [DATA_WIDTH-1:0] v;
    for (int i = 0; i < DATA_WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic desc_t mk_desc(input burst_e b, input logic [2:0] size, input logic [7:0] len,
                                    input logic [31:0] addr, input resp_e r, input logic last);
    desc_t d;
    d.a_x_id          = ID_WIDTH'($urandom);
    d.a_x_addr        = addr;
    d.a_x_len         = len;
    d.a_x_size        = size;
    d.a_x_burst       = b;
    d.x_resp          = r;
    d.x_last          = last;
    d.way_ind         = SET_ASSOCIATIVITY'(1) << $urandom_range(0, SET_ASSOCIATIVITY - 1);
    d.index_partition = INDEX_LENGTH'($urandom);
    return d;
  endfunction

  // Reference: list of data-way writes a descriptor must produce, from address arithmetic.
  function automatic void build_expected(input desc_t d);
    int unsigned addr, nb;
    way_inp_t w;
    exp_wr.delete();
    if (d.x_resp != RESP_OKAY) return;
    addr = d.a_x_addr;
    nb   = 1 << d.a_x_size;
    for (int i = 0; i <= int'(d.a_x_len); i++) begin
      w            = '0;
      w.cache_unit = W_CHAN_UNIT;
      w.we         = 1'b1;
      w.way_ind    = d.way_ind;
      w.line_addr  = d.index_partition;
      w.blk_offset = BLOCK_OFFSET_LENGTH'((addr / (1 << BYTE_OFFSET_LENGTH)) % (1 << BLOCK_OFFSET_LENGTH));
      w.data       = beat_data[i];
      w.strb       = beat_strb[i];
      exp_wr.push_back(w);
      if (d.a_x_burst != BURST_FIXED) addr = (addr / nb + 1) * nb;
    end
  endfunction

  task automatic idle_inputs();
    bus.desc_i          = '0;
    bus.desc_valid_i    = 1'b0;
    bus.w_chan_slv_i    = '0;
    bus.w_chan_valid_i  = 1'b0;
    bus.b_chan_ready_i  = 1'b0;
    bus.way_inp_ready_i = 1'b0;
    bus.w_unlock_gnt_i  = 1'b0;
  endtask

  // Drives one descriptor through to completion; mode 0: way ready always, 1: toggling, 2: random.
  task automatic run_desc(input desc_t d, input int mode, input int gnt_wait, input int bready_wait);
    int beat, gcnt, bcnt, cyc;
    bit fin, acc, prev_req, prev_bv;
    lock_t prev_lock;
    b_chan_t prev_b;
    got_wr.delete();
    n_drained = 0; n_unlock = 0; n_b = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    unlock_cyc = -1; b_cyc = -1; way_valid_seen = 0; unlock_unstable = 0; b_unstable = 0;
    ready_early = 0; wready_mismatch = 0; unlock_req_cycles = 0; b_valid_cycles = 0;
    idle_after = 0; timed_out = 0;
    for (int i = 0; i <= int'(d.a_x_len); i++) begin
      beat_data[i] = rand_data();
      beat_strb[i] = {$urandom, $urandom};
    end
    bus.desc_i = d;
    bus.desc_valid_i = 1'b1;
    @(negedge clk);
    acc = bus.desc_ready_o;
    @(posedge clk); #1;
    bus.desc_valid_i = 1'b0;
    if (!acc) timed_out = 1;
    beat = 0; gcnt = 0; bcnt = 0; fin = 0; prev_req = 0; prev_bv = 0;
    prev_lock = '0; prev_b = '0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      bus.w_chan_valid_i = (beat <= int'(d.a_x_len));
      if (beat <= int'(d.a_x_len)) begin
        bus.w_chan_slv_i.data = beat_data[beat];
        bus.w_chan_slv_i.strb = beat_strb[beat];
      end
      case (mode)
        0:       bus.way_inp_ready_i = 1'b1;
        1:       bus.way_inp_ready_i = (cyc % 2 == 0);
        default: bus.way_inp_ready_i = 1'($urandom_range(0, 1));
      endcase
      bus.w_unlock_gnt_i = bus.w_unlock_req_o && (gcnt >= gnt_wait);
      bus.b_chan_ready_i = bus.b_chan_valid_o && (bcnt >= bready_wait);
      @(negedge clk);
      if (fin) begin
        idle_after = bus.desc_ready_o;
        break;
      end
      if (bus.desc_ready_o) ready_early++;
      if (bus.w_chan_valid_i && d.x_resp == RESP_OKAY && bus.w_chan_ready_o !== bus.way_inp_ready_i)
        wready_mismatch++;
      if (bus.w_chan_valid_i && bus.w_chan_ready_o) begin
        beat++;
        n_drained++;
      end
      if (bus.way_inp_valid_o) way_valid_seen++;
      if (bus.way_inp_valid_o && bus.way_inp_ready_i) begin
        got_wr.push_back(bus.way_inp_o);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (bus.w_unlock_req_o) begin
        unlock_req_cycles++;
        if (unlock_cyc < 0) unlock_cyc = cyc;
        if (prev_req && bus.w_unlock_o !== prev_lock) unlock_unstable++;
        if (bus.w_unlock_gnt_i) begin
          n_unlock++;
          got_unlock = bus.w_unlock_o;
          if (!d.x_last) fin = 1;
        end else begin
          gcnt++;
        end
      end
      prev_req  = bus.w_unlock_req_o && !bus.w_unlock_gnt_i;
      prev_lock = bus.w_unlock_o;
      if (bus.b_chan_valid_o) begin
        b_valid_cycles++;
        if (b_cyc < 0) b_cyc = cyc;
        if (prev_bv && bus.b_chan_slv_o !== prev_b) b_unstable++;
        if (bus.b_chan_ready_i) begin
          n_b++;
          got_b = bus.b_chan_slv_o;
          fin = 1;
        end else begin
          bcnt++;
        end
      end
      prev_bv = bus.b_chan_valid_o && !bus.b_chan_ready_i;
      prev_b  = bus.b_chan_slv_o;
      @(posedge clk); #1;
    end
    if (cyc >= 4000) timed_out = 1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.w_chan_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.desc_ready_o !== 1'b1) $display("FAIL reset_desc_ready got %b exp 1", bus.desc_ready_o); else n_pass++;
    n_checks++; if (bus.w_chan_ready_o !== 1'b0) $display("FAIL reset_w_ready got %b exp 0", bus.w_chan_ready_o); else n_pass++;
    n_checks++; if (bus.way_inp_valid_o !== 1'b0) $display("FAIL reset_way_valid got %b exp 0", bus.way_inp_valid_o); else n_pass++;
    n_checks++; if (bus.w_unlock_req_o !== 1'b0) $display("FAIL reset_unlock_req got %b exp 0", bus.w_unlock_req_o); else n_pass++;
    n_checks++; if (bus.b_chan_valid_o !== 1'b0) $display("FAIL reset_b_valid got %b exp 0", bus.b_chan_valid_o); else n_pass++;
    n_checks++; if (bus.b_chan_slv_o !== '0) $display("FAIL reset_b_payload got %h exp 0", bus.b_chan_slv_o); else n_pass++;
    n_checks++; if (bus.w_unlock_o !== '0) $display("FAIL reset_unlock_payload got %h exp 0", bus.w_unlock_o); else n_pass++;
    n_checks++;
    if (bus.way_inp_o.way_ind !== '0 || bus.way_inp_o.line_addr !== '0 || bus.way_inp_o.blk_offset !== '0)
      $display("FAIL reset_way_fields got way %h line %h blk %h exp 0", bus.way_inp_o.way_ind,
               bus.way_inp_o.line_addr, bus.way_inp_o.blk_offset);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_incr_single();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'd6, 8'd3, 32'h40, RESP_OKAY, 1'b1);
    run_desc(d, 0, 0, 0);
    build_expected(d);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL incr_timeout got %b exp 0", timed_out); else n_pass++;
    n_checks++; if (got_wr.size() !== 4) $display("FAIL incr_wr_count got %0d exp 4", got_wr.size()); else n_pass++;
    for (int i = 0; i < got_wr.size() && i < 4; i++) begin
      n_checks++;
      if (got_wr[i].blk_offset !== BLOCK_OFFSET_LENGTH'(i + 1))
        $display("FAIL incr_blk%0d got %0d exp %0d", i, got_wr[i].blk_offset, i + 1);
      else n_pass++;
      n_checks++;
      if (got_wr[i] !== exp_wr[i])
        $display("FAIL incr_wr%0d got data %h way %h exp data %h way %h", i, got_wr[i].data[31:0],
                 got_wr[i].way_ind, exp_wr[i].data[31:0], exp_wr[i].way_ind);
      else n_pass++;
    end
    n_checks++; if (first_wr_cyc !== 0 || last_wr_cyc !== 3) $display("FAIL incr_wr_timing got %0d..%0d exp 0..3", first_wr_cyc, last_wr_cyc); else n_pass++;
    n_checks++; if (unlock_cyc !== 4) $display("FAIL incr_unlock_cycle got %0d exp 4", unlock_cyc); else n_pass++;
    n_checks++;
    if (got_unlock.index !== d.index_partition || got_unlock.way_ind !== d.way_ind)
      $display("FAIL incr_unlock got %h/%h exp %h/%h", got_unlock.index, got_unlock.way_ind, d.index_partition, d.way_ind);
    else n_pass++;
    n_checks++; if (b_cyc !== 5) $display("FAIL incr_b_cycle got %0d exp 5", b_cyc); else n_pass++;
    n_checks++;
    if (n_b !== 1 || got_b.id !== d.a_x_id || got_b.resp !== RESP_OKAY)
      $display("FAIL incr_b got n=%0d id %h resp %0d exp n=1 id %h resp 0", n_b, got_b.id, got_b.resp, d.a_x_id);
    else n_pass++;
  endtask

  task automatic test_non_final();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'd6, 8'd0, $urandom, RESP_OKAY, 1'b0);
    run_desc(d, 0, 0, 0);
    n_checks++; if (got_wr.size() !== 1) $display("FAIL nonfinal_wr_count got %0d exp 1", got_wr.size()); else n_pass++;
    n_checks++; if (n_unlock !== 1) $display("FAIL nonfinal_unlock_count got %0d exp 1", n_unlock); else n_pass++;
    n_checks++; if (b_valid_cycles !== 0) $display("FAIL nonfinal_b_valid got %0d exp 0", b_valid_cycles); else n_pass++;
    n_checks++; if (idle_after !== 1'b1) $display("FAIL nonfinal_ready_after got %b exp 1", idle_after); else n_pass++;
  endtask

  task automatic test_fixed_stall();
    desc_t d;
    d = mk_desc(BURST_FIXED, 3'd6, 8'd2, $urandom, RESP_OKAY, 1'b1);
    run_desc(d, 1, 0, 0);
    build_expected(d);
    n_checks++; if (got_wr.size() !== 3) $display("FAIL fixed_wr_count got %0d exp 3", got_wr.size()); else n_pass++;
    for (int i = 0; i < got_wr.size() && i < 3; i++) begin
      n_checks++;
      if (got_wr[i] !== exp_wr[i])
        $display("FAIL fixed_wr%0d got blk %0d data %h exp blk %0d data %h", i, got_wr[i].blk_offset,
                 got_wr[i].data[31:0], exp_wr[i].blk_offset, exp_wr[i].data[31:0]);
      else n_pass++;
    end
    n_checks++; if (wready_mismatch !== 0) $display("FAIL fixed_w_ready_follow got %0d exp 0", wready_mismatch); else n_pass++;
    n_checks++; if (last_wr_cyc !== 4) $display("FAIL fixed_last_wr_cycle got %0d exp 4", last_wr_cyc); else n_pass++;
  endtask

  task automatic test_error();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'd6, 8'd1, $urandom, RESP_SLVERR, 1'b1);
    run_desc(d, 2, 0, 0);
    n_checks++; if (n_drained !== 2) $display("FAIL err_drained got %0d exp 2", n_drained); else n_pass++;
    n_checks++; if (way_valid_seen !== 0) $display("FAIL err_way_valid got %0d exp 0", way_valid_seen); else n_pass++;
    n_checks++; if (n_unlock !== 1) $display("FAIL err_unlock_count got %0d exp 1", n_unlock); else n_pass++;
    n_checks++;
    if (n_b !== 1 || got_b.resp !== RESP_SLVERR || got_b.id !== d.a_x_id)
      $display("FAIL err_b got n=%0d resp %0d id %h exp n=1 resp 2 id %h", n_b, got_b.resp, got_b.id, d.a_x_id);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'($urandom_range(0, 6)), 8'($urandom_range(0, 3)), $urandom, RESP_OKAY, 1'b1);
    run_desc(d, 2, 5, 3);
    n_checks++; if (unlock_req_cycles !== 6) $display("FAIL bp_unlock_req_cycles got %0d exp 6", unlock_req_cycles); else n_pass++;
    n_checks++; if (b_valid_cycles !== 4) $display("FAIL bp_b_valid_cycles got %0d exp 4", b_valid_cycles); else n_pass++;
    n_checks++; if (unlock_unstable !== 0) $display("FAIL bp_unlock_stable got %0d exp 0", unlock_unstable); else n_pass++;
    n_checks++; if (b_unstable !== 0) $display("FAIL bp_b_stable got %0d exp 0", b_unstable); else n_pass++;
    n_checks++; if (ready_early !== 0) $display("FAIL bp_desc_ready_busy got %0d exp 0", ready_early); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'd6, 8'd3, $urandom, RESP_OKAY, 1'b1);
    bus.desc_i = d;
    bus.desc_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.desc_valid_i    = 1'b0;
    bus.w_chan_valid_i  = 1'b1;
    bus.way_inp_ready_i = 1'b1;
    bus.w_chan_slv_i    = {rand_data(), {$urandom, $urandom}};
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.way_inp_valid_o !== 1'b1) $display("FAIL rstmid_writing got %b exp 1", bus.way_inp_valid_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.desc_ready_o !== 1'b1) $display("FAIL rstmid_idle got %b exp 1", bus.desc_ready_o); else n_pass++;
    n_checks++;
    if (bus.way_inp_valid_o !== 1'b0 || bus.w_chan_ready_o !== 1'b0 || bus.w_unlock_req_o !== 1'b0 || bus.b_chan_valid_o !== 1'b0)
      $display("FAIL rstmid_valids got way %b wr %b req %b b %b exp 0", bus.way_inp_valid_o,
               bus.w_chan_ready_o, bus.w_unlock_req_o, bus.b_chan_valid_o);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    d = mk_desc(BURST_WRAP, 3'd5, 8'd2, $urandom, RESP_OKAY, 1'b1);
    run_desc(d, 0, 1, 1);
    build_expected(d);
    n_checks++; if (got_wr !== exp_wr) $display("FAIL rstmid_next_writes got %0d beats exp %0d", got_wr.size(), exp_wr.size()); else n_pass++;
    n_checks++; if (n_b !== 1 || got_b.id !== d.a_x_id) $display("FAIL rstmid_next_b got n=%0d id %h exp n=1 id %h", n_b, got_b.id, d.a_x_id); else n_pass++;
  endtask

  task automatic test_len_max();
    desc_t d;
    d = mk_desc(BURST_INCR, 3'd6, 8'd255, 32'h0, RESP_OKAY, 1'b1);
    run_desc(d, 2, 0, 0);
    build_expected(d);
    n_checks++; if (n_drained !== 256) $display("FAIL len255_beats got %0d exp 256", n_drained); else n_pass++;
    n_checks++; if (got_wr !== exp_wr) $display("FAIL len255_writes got %0d beats exp %0d or payload differs", got_wr.size(), exp_wr.size()); else n_pass++;
    n_checks++; if (n_b !== 1) $display("FAIL len255_b got %0d exp 1", n_b); else n_pass++;
  endtask

  task automatic test_random();
    desc_t d;
    resp_e r;
    for (int it = 0; it < 12; it++) begin
      r = ($urandom_range(0, 3) == 0) ? resp_e'($urandom_range(1, 3)) : RESP_OKAY;
      d = mk_desc(burst_e'($urandom_range(0, 2)), 3'($urandom_range(0, 6)), 8'($urandom_range(0, 12)),
                  $urandom, r, 1'($urandom_range(0, 1)));
      run_desc(d, 2, $urandom_range(0, 3), $urandom_range(0, 3));
      build_expected(d);
      n_checks++; if (timed_out !== 1'b0) $display("FAIL rand%0d_timeout got %b exp 0", it, timed_out); else n_pass++;
      n_checks++; if (got_wr.size() !== exp_wr.size()) $display("FAIL rand%0d_wr_count got %0d exp %0d", it, got_wr.size(), exp_wr.size()); else n_pass++;
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
        n_checks++;
        if (got_wr[i] !== exp_wr[i])
          $display("FAIL rand%0d_wr%0d got blk %0d data %h exp blk %0d data %h", it, i, got_wr[i].blk_offset,
                   got_wr[i].data[31:0], exp_wr[i].blk_offset, exp_wr[i].data[31:0]);
        else n_pass++;
      end
      n_checks++; if (n_drained !== int'(d.a_x_len) + 1) $display("FAIL rand%0d_drained got %0d exp %0d", it, n_drained, int'(d.a_x_len) + 1); else n_pass++;
      n_checks++;
      if (n_unlock !== 1 || got_unlock.index !== d.index_partition || got_unlock.way_ind !== d.way_ind)
        $display("FAIL rand%0d_unlock got n=%0d %h/%h exp n=1 %h/%h", it, n_unlock, got_unlock.index,
                 got_unlock.way_ind, d.index_partition, d.way_ind);
      else n_pass++;
      n_checks++;
      if (n_b !== int'(d.x_last) || (d.x_last && (got_b.id !== d.a_x_id || got_b.resp !== d.x_resp)))
        $display("FAIL rand%0d_b got n=%0d id %h resp %0d exp n=%0d id %h resp %0d", it, n_b, got_b.id,
                 got_b.resp, d.x_last, d.a_x_id, d.x_resp);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_incr_single();
    test_non_final();
    test_fixed_stall();
    test_error();
    test_backpressure();
    test_reset_mid_burst();
    test_len_max();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
